// File: rtl/pr_line_pkg.sv
// rtl/pr_line_pkg.sv - shared types and sizing helpers for the line word sequencer
package pr_line_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int LINE_FULL_WIDTH = 512;
    localparam int LINE_WIDTH      = 64;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    localparam int LINE_IDX_W = idx_width(LINE_FULL_WIDTH / LINE_WIDTH);

    // Parked line in the prefetch slot: start index plus already-clamped count.
    typedef struct packed {
        logic [0:LINE_FULL_WIDTH-1] data;
        logic [LINE_IDX_W-1:0]      start;
        logic [LINE_IDX_W:0]        count;
    } line_slot_t;

endpackage

// File: rtl/line_word_sequencer_select.sv
// rtl/line_word_sequencer_select.sv - combinational word mux, word i = line[WIDTH*i +: WIDTH]
module line_word_select
    import pr_line_pkg::*;
#(
    parameter  int FULL_WIDTH = LINE_FULL_WIDTH,
    parameter  int WIDTH      = LINE_WIDTH,
    localparam int WORDS      = FULL_WIDTH / WIDTH,
    localparam int IDX_W      = idx_width(WORDS)
) (
    input  logic [0:FULL_WIDTH-1] line,
    input  logic [IDX_W-1:0]      idx,
    output logic [WIDTH-1:0]      word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx == IDX_W'(i)) begin
                word = line[WIDTH*i +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/line_word_sequencer.sv
// rtl/line_word_sequencer.sv - streams words of a stored line from a start index; optional second line slot under LINE_PREFETCH_EN
module line_word_sequencer
    import pr_line_pkg::*;
#(
    parameter  int FULL_WIDTH = LINE_FULL_WIDTH,
    parameter  int WIDTH      = LINE_WIDTH,
    localparam int WORDS      = FULL_WIDTH / WIDTH,
    localparam int IDX_W      = idx_width(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line_valid,
    output logic                  line_ready,
    input  logic [0:FULL_WIDTH-1] line_data,
    input  logic [IDX_W-1:0]      line_start_idx,
    input  logic [IDX_W:0]        line_count,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [WIDTH-1:0]      word_data,
    output logic [IDX_W-1:0]      word_idx,
    output logic                  word_last,
    output logic                  busy
);

    localparam logic [IDX_W:0] WORDS_C = (IDX_W + 1)'(WORDS);

    state_t                  state;
    state_t                  state_n;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W:0]          remaining;
    logic [IDX_W:0]          count_clamped;
    logic [0:FULL_WIDTH-1]   act_data;
    logic                    take_line;
    logic                    take_word;
    logic                    last_hs;
    logic                    count_nz;
    logic                    load_new;

    assign word_valid    = (state == DRAIN);
    assign word_idx      = idx;
    assign word_last     = word_valid && (remaining == (IDX_W + 1)'(1));
    assign take_word     = word_valid & word_ready;
    assign take_line     = line_valid & line_ready;
    assign last_hs       = take_word & word_last;
    assign count_nz      = (line_count != '0);
    assign count_clamped = (line_count > WORDS_C) ? WORDS_C : line_count;

    line_word_select #(
        .FULL_WIDTH (FULL_WIDTH),
        .WIDTH      (WIDTH)
    ) u_select (
        .line (act_data),
        .idx  (idx),
        .word (word_data)
    );

`ifdef LINE_PREFETCH_EN
    logic       slot_full;
    line_slot_t slot;
    logic       promote;
    logic       to_slot;

    assign line_ready = rst_n & ~slot_full;
    assign busy       = word_valid | slot_full;

    always_comb begin
        state_n  = state;
        load_new = 1'b0;
        promote  = 1'b0;
        to_slot  = 1'b0;
        case (state)
            IDLE: begin
                if (take_line && count_nz) begin
                    load_new = 1'b1;
                    state_n  = DRAIN;
                end
            end
            DRAIN: begin
                // A line arriving on the last-word edge bypasses the slot entirely.
                if (last_hs) begin
                    if (slot_full) begin
                        promote = 1'b1;
                    end else if (take_line && count_nz) begin
                        load_new = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (take_line && count_nz) begin
                    to_slot = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
`else
    assign line_ready = rst_n & (state == IDLE);
    assign busy       = word_valid;

    always_comb begin
        state_n  = state;
        load_new = 1'b0;
        case (state)
            IDLE: begin
                if (take_line && count_nz) begin
                    load_new = 1'b1;
                    state_n  = DRAIN;
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            remaining <= '0;
            act_data  <= '0;
`ifdef LINE_PREFETCH_EN
            slot_full <= 1'b0;
            slot      <= '0;
`endif
        end else begin
            state <= state_n;
            if (load_new) begin
                act_data  <= line_data;
                idx       <= line_start_idx;
                remaining <= count_clamped;
            end
`ifdef LINE_PREFETCH_EN
            else if (promote) begin
                act_data  <= slot.data;
                idx       <= slot.start;
                remaining <= slot.count;
            end
`endif
            else if (take_word) begin
                idx       <= idx + 1'b1;
                remaining <= remaining - 1'b1;
            end
`ifdef LINE_PREFETCH_EN
            if (promote) begin
                slot_full <= 1'b0;
            end
            if (to_slot) begin
                slot      <= '{data: line_data, start: line_start_idx, count: count_clamped};
                slot_full <= 1'b1;
            end
`endif
        end
    end

endmodule
